// File: rtl/life_pkg.sv
// Shared types and helpers for the LED matrix scan stage of the Game of Life display.
package life_pkg;

  localparam int DEF_ROWS  = 8;
  localparam int DEF_COLS  = 8;
  localparam int MAX_COLS  = 16;
  localparam int MAX_BOARD = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_e;

  // Counters for a modulus of 1 still need a one-bit register.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_COLS-1:0] row_slice(input logic [MAX_BOARD-1:0] board,
                                                    input int unsigned row,
                                                    input int unsigned cols);
    return MAX_COLS'(board >> (row * cols));
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MAX up-counter with synchronous clear; wrap_o flags the enabled step from MAX-1 to 0.
module mod_counter
  import life_pkg::*;
#(
  parameter  int MAX = 2,
  localparam int W   = cnt_width(MAX)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign wrap_o  = en_i && (count_q == W'(MAX - 1));
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = wrap_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/life_matrix_scan.sv
// Double-buffered 8x8 LED row-multiplex driver with generation pacing pulse.
// Optional anti-ghosting blank slots between rows are enabled with `define SCAN_BLANK_EN.
module life_matrix_scan
  import life_pkg::*;
#(
  parameter int ROWS           = DEF_ROWS,
  parameter int COLS           = DEF_COLS,
  parameter int DWELL          = 1000,
  parameter int FRAMES_PER_GEN = 30,
  parameter int BLANK          = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ROWS*COLS-1:0] board_in,
  input  logic                 board_valid,
  output logic                 board_ready,
  output logic [ROWS-1:0]      row_n,
  output logic [COLS-1:0]      col,
  output logic                 frame_start,
  output logic                 gen_tick
);

  localparam int BW = ROWS * COLS;
  localparam int RW = cnt_width(ROWS);
  localparam int DW = cnt_width(DWELL);
  localparam int FW = cnt_width(FRAMES_PER_GEN);

  scan_state_e    state_q, state_d;
  logic [BW-1:0]  shadow_q, shadow_d;
  logic           shadow_full_q, shadow_full_d;
  logic [BW-1:0]  display_q, display_d;
  logic [ROWS-1:0] row_n_q, row_n_d;
  logic [COLS-1:0] col_q, col_d;
  logic           frame_start_q, frame_start_d;
  logic           gen_tick_q, gen_tick_d;

  logic           in_idle;
  logic           in_scan;
  logic [DW-1:0]  dwell_cnt;
  logic           dwell_wrap;
  logic [RW-1:0]  row_cnt;
  logic [RW-1:0]  row_inc;
  logic           frame_end;
  logic [FW-1:0]  frame_cnt;
  logic           frame_wrap;
  logic           unused_counts;

  assign in_idle = (state_q == ST_IDLE);
  assign in_scan = (state_q == ST_SCAN);

  mod_counter #(.MAX(DWELL)) u_dwell (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .clr_i  (in_idle),
    .en_i   (in_scan),
    .count_o(dwell_cnt),
    .wrap_o (dwell_wrap)
  );

  // The row counter wrapping out of the last row is exactly the end of a frame.
  mod_counter #(.MAX(ROWS)) u_row (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .clr_i  (in_idle),
    .en_i   (dwell_wrap),
    .count_o(row_cnt),
    .wrap_o (frame_end)
  );

  mod_counter #(.MAX(FRAMES_PER_GEN)) u_frame (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .clr_i  (1'b0),
    .en_i   (frame_end),
    .count_o(frame_cnt),
    .wrap_o (frame_wrap)
  );

`ifdef SCAN_BLANK_EN
  logic [cnt_width(BLANK)-1:0] blank_cnt;
  logic                        blank_wrap;

  mod_counter #(.MAX(BLANK)) u_blank (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .clr_i  (in_idle),
    .en_i   (state_q == ST_BLANK),
    .count_o(blank_cnt),
    .wrap_o (blank_wrap)
  );

  assign unused_counts = ^{dwell_cnt, frame_cnt, blank_cnt};
`else
  assign unused_counts = ^{dwell_cnt, frame_cnt, BLANK[0]};
`endif

  assign row_inc     = (row_cnt == RW'(ROWS - 1)) ? '0 : row_cnt + 1'b1;
  assign board_ready = !shadow_full_q;

  // Outputs are computed one cycle ahead so row_n/col only move on row boundaries.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    display_d     = display_q;
    row_n_d       = row_n_q;
    col_d         = col_q;
    frame_start_d = 1'b0;
    gen_tick_d    = 1'b0;

    if (board_valid && !shadow_full_q) begin
      shadow_d      = board_in;
      shadow_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        row_n_d = '1;
        col_d   = '0;
        if (shadow_full_q) begin
          display_d     = shadow_q;
          shadow_full_d = 1'b0;
          state_d       = ST_SCAN;
          frame_start_d = 1'b1;
          row_n_d       = ~ROWS'(1);
          col_d         = COLS'(row_slice(MAX_BOARD'(shadow_q), 32'd0, COLS));
        end
      end

      ST_SCAN: begin
        if (dwell_wrap) begin
          // A pending board is swapped in only here, so a frame never mixes two boards.
          if (frame_end) begin
            gen_tick_d = frame_wrap;
            if (shadow_full_q) begin
              display_d     = shadow_q;
              shadow_full_d = 1'b0;
            end
          end
`ifdef SCAN_BLANK_EN
          state_d = ST_BLANK;
          row_n_d = '1;
          col_d   = '0;
`else
          frame_start_d = frame_end;
          row_n_d       = ~(ROWS'(1) << row_inc);
          col_d         = COLS'(row_slice(MAX_BOARD'(display_d), 32'(row_inc), COLS));
`endif
        end
      end

`ifdef SCAN_BLANK_EN
      ST_BLANK: begin
        if (blank_wrap) begin
          state_d       = ST_SCAN;
          frame_start_d = (row_cnt == '0);
          row_n_d       = ~(ROWS'(1) << row_cnt);
          col_d         = COLS'(row_slice(MAX_BOARD'(display_q), 32'(row_cnt), COLS));
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        row_n_d = '1;
        col_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      display_q     <= '0;
      row_n_q       <= '1;
      col_q         <= '0;
      frame_start_q <= 1'b0;
      gen_tick_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      display_q     <= display_d;
      row_n_q       <= row_n_d;
      col_q         <= col_d;
      frame_start_q <= frame_start_d;
      gen_tick_q    <= gen_tick_d;
    end
  end

  assign row_n       = row_n_q;
  assign col         = col_q;
  assign frame_start = frame_start_q;
  assign gen_tick    = gen_tick_q;

endmodule

// File: tb/tb_life_matrix_scan.sv
// Randomized bench for life_matrix_scan against a frame-position reference model.
module tb_life_matrix_scan;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int DWELL = 4;
  localparam int FPG   = 3;
  localparam int BLANK = 2;
`ifdef SCAN_BLANK_EN
  localparam int SLOT = DWELL + BLANK;
`else
  localparam int SLOT = DWELL;
`endif
  localparam int FP = ROWS * SLOT;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [ROWS*COLS-1:0] board_in;
  logic                 board_valid;
  logic                 board_ready;
  logic [ROWS-1:0]      row_n;
  logic [COLS-1:0]      col;
  logic                 frame_start;
  logic                 gen_tick;

  always #5 clk = ~clk;

  life_matrix_scan #(
    .ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .FRAMES_PER_GEN(FPG), .BLANK(BLANK)
  ) dut (
    .clk(clk), .reset_n(reset_n), .board_in(board_in), .board_valid(board_valid),
    .board_ready(board_ready), .row_n(row_n), .col(col),
    .frame_start(frame_start), .gen_tick(gen_tick)
  );

  int compareCount  = 0;
  int mismatchCount = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Reference model: "scanning" plus the number of cycles since the first lit cycle.
  bit          mScan;
  int          mT;
  bit          mFull;
  logic [63:0] mShadow;
  logic [63:0] mDisplay;
  int          mFrames;
  bit          mGen;

  bit          holding;
  logic [63:0] holdData;
  logic [63:0] directed[$];

  task automatic modelReset();
    mScan = 0; mT = 0; mFull = 0; mShadow = '0; mDisplay = '0; mFrames = 0; mGen = 0;
  endtask

  task automatic checkAll();
    logic [7:0] eRowN, eCol;
    bit eFs;
    int pos, r, ph;
    eRowN = 8'hFF; eCol = 8'h00; eFs = 0;
    if (mScan) begin
      pos = mT % FP;
      r   = pos / SLOT;
      ph  = pos % SLOT;
      eFs = (pos == 0);
      if (ph < DWELL) begin
        eRowN = ~(8'h01 << r);
        eCol  = mDisplay[r*8 +: 8];
      end
    end
    checkOutput("row_n", 64'(row_n), 64'(eRowN));
    checkOutput("col", 64'(col), 64'(eCol));
    checkOutput("board_ready", 64'(board_ready), 64'(!mFull));
    checkOutput("frame_start", 64'(frame_start), 64'(eFs));
    checkOutput("gen_tick", 64'(gen_tick), 64'(mGen));
  endtask

  task automatic modelStep(input bit v, input logic [63:0] d, output bit accepted);
    bit oldFull;
    bit nextGen;
    oldFull  = mFull;
    nextGen  = 0;
    accepted = 0;
    if (!mScan) begin
      if (oldFull) begin
        mDisplay = mShadow; mFull = 0; mScan = 1; mT = 0;
      end
    end else begin
      if ((mT % FP) == (ROWS - 1) * SLOT + DWELL - 1) begin
        mFrames++;
        if (mFrames % FPG == 0) nextGen = 1;
        if (oldFull) begin
          mDisplay = mShadow; mFull = 0;
        end
      end
      mT++;
    end
    if (v && !oldFull) begin
      mShadow = d; mFull = 1; accepted = 1;
    end
    mGen = nextGen;
  endtask

  // One cycle: check outputs at the negedge, then drive inputs for the next posedge.
  task automatic stepOne(input int rate);
    bit acc;
    @(negedge clk);
    checkAll();
    if (!holding && rate > 0 && $urandom_range(0, rate - 1) == 0) begin
      holding = 1;
      if (directed.size() > 0) holdData = directed.pop_front();
      else                     holdData = {$urandom, $urandom};
    end
    board_valid = holding;
    board_in    = holding ? holdData : {$urandom, $urandom};
    modelStep(holding, holdData, acc);
    if (acc) holding = 0;
  endtask

  task automatic applyStimulus(input int cycles, input int rate);
    for (int i = 0; i < cycles; i++) stepOne(rate);
  endtask

  task automatic resetMidRow5();
    bit found;
    found = 0;
    for (int i = 0; i < 4 * FP && !found; i++) begin
      stepOne(0);
      if (mScan && ((mT % FP) / SLOT == 5) && ((mT % FP) % SLOT == 1)) found = 1;
    end
    checkOutput("row5_reached", 64'(found), 64'(1));
    @(posedge clk);
    #2;
    checkOutput("pre_reset_row_n", 64'(row_n), 64'(8'hDF));
    reset_n = 1'b0;
    #1;
    checkOutput("async_row_n", 64'(row_n), 64'(8'hFF));
    checkOutput("async_col", 64'(col), 64'(0));
    checkOutput("async_ready", 64'(board_ready), 64'(1));
    holding = 0;
    board_valid = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n     = 1'b0;
    board_valid = 1'b0;
    board_in    = '0;
    holding     = 0;
    holdData    = '0;
    modelReset();
    directed.push_back(64'h8040201008040201);
    directed.push_back(64'h000000000000FFFF);

    #12;
    checkOutput("rst_row_n", 64'(row_n), 64'(8'hFF));
    checkOutput("rst_col", 64'(col), 64'(0));
    checkOutput("rst_ready", 64'(board_ready), 64'(1));
    checkOutput("rst_frame_start", 64'(frame_start), 64'(0));
    checkOutput("rst_gen_tick", 64'(gen_tick), 64'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    $display("[TB] idle window with no valid");
    applyStimulus(600, 0);
    $display("[TB] directed boards then random traffic");
    applyStimulus(2500, 12);
    $display("[TB] asynchronous reset in row 5");
    resetMidRow5();
    applyStimulus(1500, 5);
    applyStimulus(1000, 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
